// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight writer tracking, load-use/early-branch stall and forward selects
// Entry i describes the instruction now in stage i (1 = EX, STAGES = WB).
module hazard_scoreboard #(
  parameter int REG_W  = 5,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16,
  localparam int SW    = $clog2(STAGES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_rs_use_i,
  input  logic             id_rt_use_i,
  input  logic             id_early_i,
  input  logic             id_wr_en_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic [SW-1:0]    id_res_stage_i,
  output logic             stall_o,
  output logic [SW-1:0]    id_fwd_rs_sel_o,
  output logic [SW-1:0]    id_fwd_rt_sel_o,
  output logic [SW-1:0]    ex_fwd_rs_sel_o,
  output logic [SW-1:0]    ex_fwd_rt_sel_o,
  output logic [CNT_W-1:0] stall_count_o
);

  logic [STAGES:1]            vld_q, vld_d, wen_q, wen_d;
  logic [STAGES:1][REG_W-1:0] rd_q, rd_d;
  logic [STAGES:1][SW-1:0]    res_q, res_d;
  logic [SW-1:0]              ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [SW-1:0]              m_rs, m_rt, p_rs, p_rt;
  logic                       hz_rs, hz_rt, hz_stall, load;

  // Descending scan so the youngest (lowest-index) producer wins; WB is left to the regfile bypass.
  always_comb begin
    m_rs = '0;
    p_rs = '0;
    m_rt = '0;
    p_rt = '0;
    for (int i = STAGES - 1; i >= 1; i--) begin
      if (vld_q[i] && wen_q[i] && rd_q[i] != '0) begin
        if (rd_q[i] == id_rs_i) begin
          m_rs = SW'(i);
          p_rs = res_q[i];
        end
        if (rd_q[i] == id_rt_i) begin
          m_rt = SW'(i);
          p_rt = res_q[i];
        end
      end
    end
  end

  assign hz_rs = id_rs_use_i && (m_rs != '0) && (id_early_i ? (m_rs <= p_rs) : (m_rs < p_rs));
  assign hz_rt = id_rt_use_i && (m_rt != '0) && (id_early_i ? (m_rt <= p_rt) : (m_rt < p_rt));
  assign hz_stall = id_valid_i && !flush_i && (hz_rs || hz_rt);
  assign load     = id_valid_i && !flush_i && !hz_stall;

  assign stall_o         = hold_i || hz_stall;
  assign id_fwd_rs_sel_o = (id_rs_use_i && !hz_rs) ? m_rs : '0;
  assign id_fwd_rt_sel_o = (id_rt_use_i && !hz_rt) ? m_rt : '0;
  assign ex_fwd_rs_sel_o = ex_rs_q;
  assign ex_fwd_rt_sel_o = ex_rt_q;
  assign stall_count_o   = cnt_q;

  always_comb begin
    vld_d   = vld_q;
    wen_d   = wen_q;
    rd_d    = rd_q;
    res_d   = res_q;
    ex_rs_d = ex_rs_q;
    ex_rt_d = ex_rt_q;
    cnt_d   = cnt_q;
    if (!hold_i) begin
      for (int i = STAGES; i >= 2; i--) begin
        vld_d[i] = vld_q[i-1];
        wen_d[i] = wen_q[i-1];
        rd_d[i]  = rd_q[i-1];
        res_d[i] = res_q[i-1];
      end
      if (load) begin
        vld_d[1] = 1'b1;
        wen_d[1] = id_wr_en_i;
        rd_d[1]  = id_rd_i;
        res_d[1] = id_res_stage_i;
        // One stage further on by the time the operand is consumed in EX.
        ex_rs_d  = (id_rs_use_i && m_rs != '0) ? m_rs + SW'(1) : '0;
        ex_rt_d  = (id_rt_use_i && m_rt != '0) ? m_rt + SW'(1) : '0;
      end else begin
        vld_d[1] = 1'b0;
        wen_d[1] = 1'b0;
        rd_d[1]  = '0;
        res_d[1] = '0;
        ex_rs_d  = '0;
        ex_rt_d  = '0;
      end
      if (hz_stall && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q   <= '0;
      wen_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      ex_rs_q <= '0;
      ex_rt_q <= '0;
      cnt_q   <= '0;
    end else begin
      vld_q   <= vld_d;
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      ex_rs_q <= ex_rs_d;
      ex_rt_q <= ex_rt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - random and directed checks of hazard_scoreboard against an age-based model
module tb_hazard_scoreboard;

  localparam int NST = 3;

  logic        clk = 1'b0;
  logic        rst, hold, flush, id_valid, id_rs_use, id_rt_use, id_early, id_wr_en;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_res_stage;
  logic        stall;
  logic [1:0]  id_fwd_rs_sel, id_fwd_rt_sel, ex_fwd_rs_sel, ex_fwd_rt_sel;
  logic [15:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit v;
    bit w;
    int rd;
    int res;
  } instr_t;

  instr_t pipe [1:NST];
  int     mdl_ex_rs, mdl_ex_rt, mdl_cnt;
  int     e_mrs, e_mrt;
  bit     e_hz;

  hazard_scoreboard dut (
    .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
    .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_rs_use_i(id_rs_use), .id_rt_use_i(id_rt_use), .id_early_i(id_early),
    .id_wr_en_i(id_wr_en), .id_rd_i(id_rd), .id_res_stage_i(id_res_stage),
    .stall_o(stall), .id_fwd_rs_sel_o(id_fwd_rs_sel), .id_fwd_rt_sel_o(id_fwd_rt_sel),
    .ex_fwd_rs_sel_o(ex_fwd_rs_sel), .ex_fwd_rt_sel_o(ex_fwd_rt_sel),
    .stall_count_o(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t bubble();
    instr_t b;
    b.v = 0; b.w = 0; b.rd = 0; b.res = 0;
    return b;
  endfunction

  // Age of the youngest in-flight writer of r, ignoring the writeback slot.
  function automatic int youngest_writer(input int r);
    if (r == 0) return 0;
    for (int age = 1; age < NST; age++)
      if (pipe[age].v && pipe[age].w && pipe[age].rd == r) return age;
    return 0;
  endfunction

  // A producer at age m has finished m-1 stages now and m stages by next cycle's EX.
  function automatic bit not_ready(input int m, input bit early);
    int done;
    if (m == 0) return 0;
    done = early ? m - 1 : m;
    return done < pipe[m].res;
  endfunction

  function automatic void model_clear();
    for (int a = 1; a <= NST; a++) pipe[a] = bubble();
    mdl_ex_rs = 0;
    mdl_ex_rt = 0;
    mdl_cnt   = 0;
  endfunction

  task automatic eval_and_check();
    bit hrs, hrt;
    e_mrs = youngest_writer(int'(id_rs));
    e_mrt = youngest_writer(int'(id_rt));
    hrs   = id_rs_use && not_ready(e_mrs, id_early);
    hrt   = id_rt_use && not_ready(e_mrt, id_early);
    e_hz  = id_valid && !flush && (hrs || hrt);
    check_eq("stall",     int'(stall),         int'(hold || e_hz));
    check_eq("id_rs_sel", int'(id_fwd_rs_sel), (id_rs_use && !hrs) ? e_mrs : 0);
    check_eq("id_rt_sel", int'(id_fwd_rt_sel), (id_rt_use && !hrt) ? e_mrt : 0);
    check_eq("ex_rs_sel", int'(ex_fwd_rs_sel), mdl_ex_rs);
    check_eq("ex_rt_sel", int'(ex_fwd_rt_sel), mdl_ex_rt);
    check_eq("stall_cnt", int'(stall_count),   mdl_cnt);
  endtask

  function automatic void model_advance();
    instr_t n;
    if (hold) return;
    for (int a = NST; a >= 2; a--) pipe[a] = pipe[a-1];
    if (id_valid && !flush && !e_hz) begin
      n.v = 1; n.w = id_wr_en; n.rd = int'(id_rd); n.res = int'(id_res_stage);
      pipe[1]   = n;
      mdl_ex_rs = (id_rs_use && e_mrs != 0) ? e_mrs + 1 : 0;
      mdl_ex_rt = (id_rt_use && e_mrt != 0) ? e_mrt + 1 : 0;
    end else begin
      pipe[1]   = bubble();
      mdl_ex_rs = 0;
      mdl_ex_rt = 0;
    end
    if (e_hz && mdl_cnt < 65535) mdl_cnt++;
  endfunction

  task automatic step(input bit r, input bit h, input bit f, input bit v,
                      input int a, input int b, input bit ua, input bit ub, input bit e,
                      input bit w, input int d, input int rs);
    @(negedge clk);
    rst = r; hold = h; flush = f; id_valid = v;
    id_rs = 5'(a); id_rt = 5'(b); id_rs_use = ua; id_rt_use = ub; id_early = e;
    id_wr_en = w; id_rd = 5'(d); id_res_stage = 2'(rs);
    #1;
    if (r) model_clear();
    eval_and_check();
    @(posedge clk);
    if (!r) model_advance();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1; hold = 0; flush = 0; id_valid = 0; id_rs = 0; id_rt = 0;
    id_rs_use = 0; id_rt_use = 0; id_early = 0; id_wr_en = 0; id_rd = 0; id_res_stage = 0;
    model_clear();

    // ALU -> ALU forward
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 3, 1);
    step(0, 0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 1);
    #1 check_eq("alu_fwd_ex_rs", int'(ex_fwd_rs_sel), 2);

    // load-use: one stall then forward from stage 3
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 4, 2);
    step(0, 0, 0, 1, 0, 4, 0, 1, 0, 0, 0, 1);
    #1 check_eq("load_use_cnt", int'(stall_count), 1);
    step(0, 0, 0, 1, 0, 4, 0, 1, 0, 0, 0, 1);
    #1 check_eq("load_use_ex_rt", int'(ex_fwd_rt_sel), 3);

    // ALU -> beq, load -> beq, flush and $0 cases
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 5, 1);
    step(0, 0, 0, 1, 5, 0, 1, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 5, 0, 1, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 6, 2);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 6, 0, 1, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 7, 2);
    step(0, 0, 1, 1, 7, 7, 1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2);
    step(0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 1);

    // hold across a pending load-use, then reset mid-stall
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2, 2);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 1, 2, 2, 1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 2, 2, 1, 1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 2, 2, 1, 1, 0, 0, 0, 1);
    idle();

    for (int c = 0; c < 800; c++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 85,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
